// File: rtl/freq_div_ctrl.sv
// Run-time controller for the programmable frequency divider: ratio handshake, start/stop, Tick/Div_Out.
// Optional burst mode (auto-stop after Burst_Len ticks) is compiled in with FREQ_DIV_BURST_EN.
module freq_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int BURST_W     = 8,
    parameter int RESET_RATIO = 2
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Cfg_Valid,
    input  logic [WIDTH-1:0]   Cfg_Ratio,
    output logic               Cfg_Ready,
    input  logic [BURST_W-1:0] Burst_Len,
    output logic               Tick,
    output logic               Div_Out,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Active_Ratio
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic [WIDTH-1:0] pend_ratio, pend_nxt;
    logic [WIDTH-1:0] ratio_nxt;
    logic [WIDTH-1:0] reff;
    logic             tick_nxt, div_nxt, done_nxt;
    logic             xfer, wrap, burst_end, start_go;

    // Ratios 0 and 1 both mean "tick every cycle".
    assign reff     = (Active_Ratio == '0) ? WIDTH'(1) : Active_Ratio;
    assign wrap     = (state != IDLE) && (count == reff - WIDTH'(1));
    assign xfer     = Cfg_Valid && Cfg_Ready;
    assign start_go = (state == IDLE) && Start && !Stop;

`ifdef FREQ_DIV_BURST_EN
    logic [BURST_W-1:0] burst_cnt;
    logic               burst_on;

    assign burst_end = burst_on && wrap && !Stop && (burst_cnt == BURST_W'(1));

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            burst_cnt <= '0;
            burst_on  <= 1'b0;
        end else if (start_go) begin
            burst_cnt <= Burst_Len;
            burst_on  <= (Burst_Len != '0);
        end else if (burst_on && wrap && !Stop) begin
            burst_cnt <= burst_cnt - BURST_W'(1);
        end
    end
`else
    // Continuous-only build: Burst_Len is kept on the port list but has no effect.
    assign burst_end = 1'b0 & (|Burst_Len);
`endif

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Start && !Stop) state_nxt = RUN;
            RUN: begin
                if (Stop || burst_end) state_nxt = IDLE;
                else if (xfer)         state_nxt = PEND;
            end
            PEND: begin
                if (Stop || burst_end) state_nxt = IDLE;
                else if (wrap)         state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        ratio_nxt = Active_Ratio;
        pend_nxt  = pend_ratio;
        tick_nxt  = 1'b0;
        div_nxt   = Div_Out;
        done_nxt  = burst_end;
        case (state)
            IDLE: begin
                if (xfer) ratio_nxt = Cfg_Ratio;
                if (start_go) begin
                    count_nxt = '0;
                    div_nxt   = 1'b0;
                end
            end
            RUN, PEND: begin
                if (Stop) begin
                    // Halting commits whatever ratio is waiting; no Tick on this edge.
                    count_nxt = '0;
                    div_nxt   = 1'b0;
                    if (state == PEND) ratio_nxt = pend_ratio;
                    else if (xfer)     ratio_nxt = Cfg_Ratio;
                end else begin
                    if (wrap) begin
                        count_nxt = '0;
                        tick_nxt  = 1'b1;
                        div_nxt   = ~Div_Out;
                        if (state == PEND) ratio_nxt = pend_ratio;
                    end else begin
                        count_nxt = count + WIDTH'(1);
                    end
                    // A transfer landing on the burst-ending edge goes straight to Active_Ratio.
                    if (xfer) begin
                        if (burst_end) ratio_nxt = Cfg_Ratio;
                        else           pend_nxt  = Cfg_Ratio;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            count        <= '0;
            pend_ratio   <= '0;
            Active_Ratio <= WIDTH'(RESET_RATIO);
            Tick         <= 1'b0;
            Div_Out      <= 1'b0;
            Done         <= 1'b0;
            Busy         <= 1'b0;
            Cfg_Ready    <= 1'b1;
        end else begin
            count        <= count_nxt;
            pend_ratio   <= pend_nxt;
            Active_Ratio <= ratio_nxt;
            Tick         <= tick_nxt;
            Div_Out      <= div_nxt;
            Done         <= done_nxt;
            Busy         <= (state_nxt != IDLE);
            Cfg_Ready    <= (state_nxt != PEND);
        end
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: reset, steady division, ratio change, edge ratios,
// simultaneous events and burst/continuous behaviour.
module tb_freq_div_ctrl;

    logic       Clock = 1'b0;
    logic       Clear, Start, Stop, Cfg_Valid;
    logic [7:0] Cfg_Ratio;
    logic       Cfg_Ready;
    logic [7:0] Burst_Len;
    logic       Tick, Div_Out, Busy, Done;
    logic [7:0] Active_Ratio;

    int errors = 0;
    int checks = 0;
    int n;
    logic exp_div;

    freq_div_ctrl dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop),
        .Cfg_Valid(Cfg_Valid), .Cfg_Ratio(Cfg_Ratio), .Cfg_Ready(Cfg_Ready),
        .Burst_Len(Burst_Len), .Tick(Tick), .Div_Out(Div_Out), .Busy(Busy),
        .Done(Done), .Active_Ratio(Active_Ratio)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Returns number of edges until Tick is seen, or -1 if the bound expires.
    task automatic wait_tick(input int lim, output int cnt);
        cnt = 0;
        while (cnt < lim) begin
            cyc();
            cnt++;
            if (Tick) return;
        end
        cnt = -1;
    endtask

    task automatic load(input logic [7:0] r);
        Cfg_Valid = 1'b1;
        Cfg_Ratio = r;
        cyc();
        Cfg_Valid = 1'b0;
    endtask

    task automatic go();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    task automatic halt();
        Stop = 1'b1;
        cyc();
        Stop = 1'b0;
    endtask

    initial begin
        Clear = 1'b1; Start = 0; Stop = 0; Cfg_Valid = 0; Cfg_Ratio = 0; Burst_Len = 0;
        repeat (3) begin
            cyc();
            chk("tick_in_reset", Tick, 0);
        end
        Clear = 1'b0;
        cyc();
        chk("rst_tick", Tick, 0);
        chk("rst_div", Div_Out, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_ready", Cfg_Ready, 1);
        chk("rst_ratio", Active_Ratio, 2);

        // Steady division at R=4
        load(8'd4);
        chk("idle_load", Active_Ratio, 4);
        go();
        chk("start_busy", Busy, 1);
        chk("start_tick", Tick, 0);
        exp_div = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_tick(50, n);
            exp_div = ~exp_div;
            chk("r4_period", n, 4);
            chk("r4_div", Div_Out, exp_div);
        end
        halt();
        chk("stop_busy", Busy, 0);
        chk("stop_div", Div_Out, 0);

        // Mid-run change 6 -> 3, transfer two cycles after a Tick
        load(8'd6);
        go();
        wait_tick(50, n);
        chk("r6_first", n, 6);
        cyc(); cyc();
        load(8'd3);
        chk("pend_ready", Cfg_Ready, 0);
        chk("pend_ratio_old", Active_Ratio, 6);
        wait_tick(50, n);
        chk("r6_finish", n, 3);
        chk("commit_ratio", Active_Ratio, 3);
        chk("commit_ready", Cfg_Ready, 1);
        for (int i = 0; i < 2; i++) begin
            wait_tick(50, n);
            chk("r3_period", n, 3);
        end

        // Stop while PEND on what would be the terminal edge
        load(8'd5);
        chk("pend2_ready", Cfg_Ready, 0);
        cyc();
        halt();
        chk("pstop_tick", Tick, 0);
        chk("pstop_busy", Busy, 0);
        chk("pstop_ratio", Active_Ratio, 5);
        chk("pstop_ready", Cfg_Ready, 1);

        // Edge ratios 0 and 1
        for (int r = 0; r < 2; r++) begin
            load(r[7:0]);
            go();
            exp_div = 1'b0;
            for (int i = 0; i < 4; i++) begin
                cyc();
                exp_div = ~exp_div;
                chk("r01_tick", Tick, 1);
                chk("r01_div", Div_Out, exp_div);
            end
            halt();
        end

        // R=255
        load(8'd255);
        go();
        for (int i = 0; i < 2; i++) begin
            wait_tick(600, n);
            chk("r255_period", n, 255);
        end
        halt();

        // Start and Stop together
        Start = 1'b1; Stop = 1'b1;
        cyc();
        Start = 1'b0; Stop = 1'b0;
        chk("startstop_busy", Busy, 0);
        cyc(); cyc();
        chk("startstop_tick", Tick, 0);

        // Start with a Cfg transfer of R=7
        Cfg_Valid = 1'b1; Cfg_Ratio = 8'd7; Start = 1'b1;
        cyc();
        Cfg_Valid = 1'b0; Start = 1'b0;
        chk("cfgstart_ratio", Active_Ratio, 7);
        chk("cfgstart_busy", Busy, 1);
        wait_tick(50, n);
        chk("r7_first", n, 7);
        halt();

        // Burst: 3 ticks at R=2
        load(8'd2);
        Burst_Len = 8'd3;
        go();
        Burst_Len = 8'd0;
`ifdef FREQ_DIV_BURST_EN
        for (int i = 0; i < 3; i++) begin
            wait_tick(50, n);
            chk("burst_period", n, 2);
            chk("burst_done", Done, (i == 2) ? 1 : 0);
        end
        cyc();
        chk("burst_idle", Busy, 0);
        chk("burst_done_pulse", Done, 0);
        cyc(); cyc(); cyc();
        chk("burst_no_tick", Tick, 0);
`else
        for (int i = 0; i < 4; i++) begin
            wait_tick(50, n);
            chk("cont_period", n, 2);
            chk("cont_done", Done, 0);
        end
        chk("cont_busy", Busy, 1);
        halt();
`endif

        // Clear mid-run with R=5 and a pending ratio
        load(8'd5);
        go();
        wait_tick(50, n);
        chk("r5_first", n, 5);
        load(8'd9);
        chk("clr_pre_ready", Cfg_Ready, 0);
        chk("clr_pre_div", Div_Out, 1);
        #2 Clear = 1'b1;
        #1;
        chk("clr_tick", Tick, 0);
        chk("clr_div", Div_Out, 0);
        chk("clr_busy", Busy, 0);
        chk("clr_ready", Cfg_Ready, 1);
        chk("clr_ratio", Active_Ratio, 2);
        cyc();
        Clear = 1'b0;
        cyc(); cyc();
        chk("clr_after_ratio", Active_Ratio, 2);
        chk("clr_after_busy", Busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
